// File: rtl/sram_req_arbiter_pkg.sv
// Purpose: shared types and constants for the instruction/data sram request arbiter.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: owner ids (ARB_ID_INST / ARB_ID_DATA), lock FSM state encodings,
//           the downstream request field bundle and the request size code.
package sram_req_arbiter_pkg;

    // Owner id carried through the in-order return FIFO.
    typedef logic arb_id_t;
    localparam arb_id_t ARB_ID_INST = 1'b0;
    localparam arb_id_t ARB_ID_DATA = 1'b1;

    // Address-phase lock FSM: while a request is presented but not yet
    // accepted, the grant is pinned to that master.
    typedef enum logic [1:0] {
        LOCK_IDLE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    // Request fields driven downstream alongside sram_req.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    // Fetches are always word reads with no write payload.
    function automatic sram_req_t inst_req_fields(input logic [31:0] addr);
        sram_req_t r;
        r       = '0;
        r.size  = SRAM_SIZE_WORD;
        r.addr  = addr;
        return r;
    endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// Purpose: one sram-like bus (req/addr_ok/data_ok) shared by fetch, data and downstream sides.
// Latency: n/a (wiring only).
// Backpressure: addr_ok accepts the request phase, data_ok returns one response per accepted request.
// Ports: master modport drives req/wr/size/wstrb/addr/wdata and receives addr_ok/data_ok/rdata;
//        slave modport is the mirror image.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter_arb_id_fifo.sv
// Purpose: in-order FIFO of request owner ids (one entry per accepted, not-yet-returned request).
// Latency: push visible at head one cycle later; pop is combinational head read, state updates on clk.
// Backpressure: full/empty are exported; push while full and pop while empty are ignored.
// Ports: clk, resetn (async active-low), push/push_id, pop, head, full, empty.
module arb_id_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    push,
    input  arb_id_t push_id,
    input  logic    pop,
    output arb_id_t head,
    output logic    full,
    output logic    empty
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    arb_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    // One bit wider than the pointers so full and empty are distinct.
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ARB_ID_INST;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id;
                // DEPTH is a power of two, so the pointer wraps naturally.
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Purpose: share one sram-like bus between the fetch master and the data master, routing returns by owner.
// Latency: addr_ok and data_ok/rdata routed combinationally (zero cycles); owner FIFO updates on clk.
// Backpressure: request held off while OUTSTANDING responses are pending; grant locked until addr_ok.
// Ports: clk, resetn (async active-low); inst_sram / data_sram (slave side of each master bus);
//        sram (master side of the downstream bus to the AXI bridge).
// Build option: define ARB_RR_EN for round-robin IDLE arbitration; default is fixed data priority.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ID_PTR_W    = $clog2(OUTSTANDING)
) (
    input  logic                clk,
    input  logic                resetn,
    sram_req_arbiter_if.slave   inst_sram,
    sram_req_arbiter_if.slave   data_sram,
    sram_req_arbiter_if.master  sram
);

    lock_state_t state_q;
    logic        gnt_vld;
    arb_id_t     gnt_id;
    logic        gnt_req;
    logic        req_out;
    sram_req_t   req_fields;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    arb_id_t     fifo_head;

`ifdef ARB_RR_EN
    arb_id_t     rr_q;
`endif

    // Fetch requests carry no write payload; those bus wires are not consumed.
    logic unused_inst_fields;
    assign unused_inst_fields = ^{inst_sram.wr, inst_sram.size, inst_sram.wstrb, inst_sram.wdata};

    // Grant selection. Gated by resetn so every output is 0 the moment
    // reset is asserted, even if a master is still holding its request.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = ARB_ID_INST;
        if (resetn) begin
            case (state_q)
                LOCK_INST: begin
                    gnt_vld = 1'b1;
                    gnt_id  = ARB_ID_INST;
                end
                LOCK_DATA: begin
                    gnt_vld = 1'b1;
                    gnt_id  = ARB_ID_DATA;
                end
                default: begin
`ifdef ARB_RR_EN
                    if (inst_sram.req && data_sram.req) begin
                        gnt_vld = 1'b1;
                        gnt_id  = rr_q;
                    end else if (data_sram.req) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ARB_ID_DATA;
                    end else if (inst_sram.req) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ARB_ID_INST;
                    end
`else
                    if (data_sram.req) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ARB_ID_DATA;
                    end else if (inst_sram.req) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ARB_ID_INST;
                    end
`endif
                end
            endcase
        end
    end

    assign gnt_req = gnt_vld & ((gnt_id == ARB_ID_DATA) ? data_sram.req : inst_sram.req);
    // No bypass: a full FIFO blocks the request even if a pop lands this cycle.
    assign req_out = gnt_req & ~fifo_full;

    always_comb begin
        req_fields = '0;
        if (gnt_vld) begin
            if (gnt_id == ARB_ID_DATA) begin
                req_fields.wr    = data_sram.wr;
                req_fields.size  = data_sram.size;
                req_fields.wstrb = data_sram.wstrb;
                req_fields.addr  = data_sram.addr;
                req_fields.wdata = data_sram.wdata;
            end else begin
                req_fields = inst_req_fields(inst_sram.addr);
            end
        end
    end

    assign sram.req   = req_out;
    assign sram.wr    = req_fields.wr;
    assign sram.size  = req_fields.size;
    assign sram.wstrb = req_fields.wstrb;
    assign sram.addr  = req_fields.addr;
    assign sram.wdata = req_fields.wdata;

    assign push = req_out & sram.addr_ok;
    assign pop  = sram.data_ok & ~fifo_empty;

    assign inst_sram.addr_ok = push & (gnt_id == ARB_ID_INST);
    assign data_sram.addr_ok = push & (gnt_id == ARB_ID_DATA);

    // Responses are strictly in order, so the FIFO head names the owner.
    assign inst_sram.data_ok = pop & (fifo_head == ARB_ID_INST);
    assign data_sram.data_ok = pop & (fifo_head == ARB_ID_DATA);
    assign inst_sram.rdata   = inst_sram.data_ok ? sram.rdata : 32'h0;
    assign data_sram.rdata   = data_sram.data_ok ? sram.rdata : 32'h0;

    // Lock FSM: pin the grant while a presented request waits for addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOCK_IDLE;
        end else begin
            case (state_q)
                LOCK_IDLE: begin
                    if (req_out && !sram.addr_ok) begin
                        state_q <= (gnt_id == ARB_ID_DATA) ? LOCK_DATA : LOCK_INST;
                    end
                end
                LOCK_INST, LOCK_DATA: begin
                    if (req_out && sram.addr_ok) begin
                        state_q <= LOCK_IDLE;
                    end
                end
                default: state_q <= LOCK_IDLE;
            endcase
        end
    end

`ifdef ARB_RR_EN
    // Hand priority to the other master after every accepted address phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= ARB_ID_INST;
        end else if (push) begin
            rr_q <= ~gnt_id;
        end
    end
`endif

    arb_id_fifo #(
        .DEPTH (OUTSTANDING),
        .PTR_W (ID_PTR_W)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .push_id (gnt_id),
        .pop     (pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Purpose: directed-vector bench for sram_req_arbiter with a response scoreboard.
// Latency: checks combinational routing at the negedge of the driving cycle.
// Backpressure: exercises address lock, FIFO-full blocking, stray returns and mid-flight reset.
module tb_sram_req_arbiter;

    logic clk;
    logic resetn;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if mem_if  ();

    sram_req_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst_sram (inst_if),
        .data_sram (data_if),
        .sram      (mem_if)
    );

    typedef struct packed {
        logic        owner;   // 0 inst, 1 data
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] outs();
        return {20'd0, mem_if.req, mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata,
                inst_if.addr_ok, inst_if.data_ok, inst_if.rdata,
                data_if.addr_ok, data_if.data_ok, data_if.rdata};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd0; inst_if.wstrb = 4'h0;
        inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd0; data_if.wstrb = 4'h0;
        data_if.addr = 32'h0; data_if.wdata = 32'h0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
    endtask

    task automatic data_drive(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                              input logic [31:0] addr, input logic [31:0] wdata);
        data_if.req = 1'b1; data_if.wr = wr; data_if.size = size;
        data_if.wstrb = wstrb; data_if.addr = addr; data_if.wdata = wdata;
    endtask

    task automatic rsp_drive(input logic owner, input logic [31:0] rd);
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = rd;
        exp_q.push_back('{owner: owner, rdata: rd});
    endtask

    task automatic rsp_clear();
        mem_if.data_ok = 1'b0;
        mem_if.rdata   = 32'h0;
    endtask

    // Monitor: whenever a master sees data_ok, pop the scoreboard and compare.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (resetn && (inst_if.data_ok || data_if.data_ok)) begin
                if (inst_if.data_ok && data_if.data_ok) begin
                    n_tests++; n_fail++;
                    $display("FAIL both_data_ok: got inst=1 data=1, expected one owner");
                end else if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: got data_ok inst=%0b data=%0b, expected none",
                             inst_if.data_ok, data_if.data_ok);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_owner", {159'd0, data_if.data_ok}, {159'd0, e.owner});
                    check("rsp_rdata", {128'd0, (e.owner ? data_if.rdata : inst_if.rdata)},
                          {128'd0, e.rdata});
                    check("rsp_other_rdata", {128'd0, (e.owner ? inst_if.rdata : data_if.rdata)}, 160'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        settle();
        check("reset_outs", outs(), 160'd0);
        cyc(); resetn = 1'b1;
        settle();
        check("post_reset_outs", outs(), 160'd0);

        // Single fetch: accepted cycle 0, data returned cycle 3.
        cyc(); inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0000; mem_if.addr_ok = 1'b1;
        settle();
        check("t1_req_addr", {127'd0, mem_if.req, mem_if.addr}, {127'd0, 1'b1, 32'h1c00_0000});
        check("t1_fields", {88'd0, mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.wdata},
              {88'd0, 1'b0, 2'd2, 4'h0, 32'h0});
        check("t1_addr_ok", {158'd0, inst_if.addr_ok, data_if.addr_ok}, {158'd0, 2'b10});
        cyc(); idle_inputs();
        cyc();
        cyc(); rsp_drive(1'b0, 32'h0280_0000);
        settle();
        check("t1_data_side_quiet", {127'd0, data_if.data_ok, data_if.rdata}, 160'd0);
        cyc(); rsp_clear();

        // Both request together: data first, inst next cycle; returns in order.
        cyc();
        inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0004;
        data_drive(1'b1, 2'd2, 4'hf, 32'h0000_1000, 32'hdead_beef);
        mem_if.addr_ok = 1'b1;
        settle();
        check("t2_data_fields", {88'd0, mem_if.wr, mem_if.size, mem_if.wstrb, mem_if.addr, mem_if.wdata},
              {88'd0, 1'b1, 2'd2, 4'hf, 32'h0000_1000, 32'hdead_beef});
        check("t2_data_addr_ok", {158'd0, inst_if.addr_ok, data_if.addr_ok}, {158'd0, 2'b01});
        cyc(); data_drive(1'b0, 2'd0, 4'h0, 32'h0, 32'h0); data_if.req = 1'b0;
        settle();
        check("t2_inst_addr", {127'd0, mem_if.wr, mem_if.addr}, {127'd0, 1'b0, 32'h1c00_0004});
        check("t2_inst_addr_ok", {158'd0, inst_if.addr_ok, data_if.addr_ok}, {158'd0, 2'b10});
        cyc(); idle_inputs();
        cyc(); rsp_drive(1'b1, 32'h1111_1111);
        cyc(); rsp_clear(); rsp_drive(1'b0, 32'h2222_2222);
        cyc(); rsp_clear();

        // Lock: inst waits 4 cycles for addr_ok while data rises on cycle 1.
        cyc(); inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0040;
        settle();
        check("t3_c0", {126'd0, mem_if.req, inst_if.addr_ok, mem_if.addr}, {126'd0, 2'b10, 32'h1c00_0040});
        cyc(); data_drive(1'b0, 2'd0, 4'h1, 32'h0000_2000, 32'h0);
        for (int c = 1; c < 4; c++) begin
            if (c > 1) cyc();
            settle();
            check("t3_locked", {125'd0, mem_if.req, mem_if.wr, data_if.addr_ok, mem_if.addr},
                  {125'd0, 3'b100, 32'h1c00_0040});
        end
        cyc(); mem_if.addr_ok = 1'b1;
        settle();
        check("t3_inst_accept", {126'd0, inst_if.addr_ok, data_if.addr_ok, mem_if.addr},
              {126'd0, 2'b10, 32'h1c00_0040});
        cyc(); inst_if.req = 1'b0;
        settle();
        check("t3_data_accept", {121'd0, data_if.addr_ok, mem_if.size, mem_if.wstrb, mem_if.addr},
              {121'd0, 1'b1, 2'd0, 4'h1, 32'h0000_2000});
        cyc(); idle_inputs();
        cyc(); rsp_drive(1'b0, 32'h3333_3333);
        cyc(); rsp_clear(); rsp_drive(1'b1, 32'h4444_4444);
        cyc(); rsp_clear();

        // FIFO full: third request blocked until after the first return.
        cyc(); inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0100; mem_if.addr_ok = 1'b1;
        settle();
        check("t4_acc_a", {159'd0, inst_if.addr_ok}, {159'd0, 1'b1});
        cyc(); inst_if.addr = 32'h1c00_0104;
        settle();
        check("t4_acc_b", {159'd0, inst_if.addr_ok}, {159'd0, 1'b1});
        cyc(); inst_if.addr = 32'h1c00_0108;
        settle();
        check("t4_full_block", {158'd0, mem_if.req, inst_if.addr_ok}, 160'd0);
        cyc();
        settle();
        check("t4_full_hold", {158'd0, mem_if.req, inst_if.addr_ok}, 160'd0);
        cyc(); rsp_drive(1'b0, 32'h5555_5555);
        settle();
        check("t4_no_bypass", {158'd0, mem_if.req, inst_if.addr_ok}, 160'd0);
        cyc(); rsp_clear();
        settle();
        check("t4_acc_c", {126'd0, mem_if.req, inst_if.addr_ok, mem_if.addr}, {126'd0, 2'b11, 32'h1c00_0108});
        cyc(); idle_inputs();
        cyc(); rsp_drive(1'b0, 32'h6666_6666);
        cyc(); rsp_clear(); rsp_drive(1'b0, 32'h7777_7777);
        cyc(); rsp_clear();

        // Stray return with empty FIFO is ignored.
        cyc(); mem_if.data_ok = 1'b1; mem_if.rdata = 32'habcd_abcd;
        settle();
        check("t5_stray", {94'd0, inst_if.data_ok, data_if.data_ok, inst_if.rdata, data_if.rdata}, 160'd0);
        cyc(); rsp_clear(); data_drive(1'b0, 2'd2, 4'h0, 32'h0000_3000, 32'h0); mem_if.addr_ok = 1'b1;
        settle();
        check("t5_acc_1", {159'd0, data_if.addr_ok}, {159'd0, 1'b1});
        cyc(); data_if.addr = 32'h0000_3004;
        settle();
        check("t5_acc_2", {159'd0, data_if.addr_ok}, {159'd0, 1'b1});
        cyc(); data_if.addr = 32'h0000_3008;
        settle();
        check("t5_full_after_two", {158'd0, mem_if.req, data_if.addr_ok}, 160'd0);

        // Reset with two outstanding and both masters still requesting.
        cyc(); inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0200; resetn = 1'b0;
        #1;
        check("t6_reset_outs", outs(), 160'd0);
        cyc(); resetn = 1'b1; inst_if.req = 1'b0;
        settle();
        check("t6_fifo_empty", {126'd0, mem_if.req, data_if.addr_ok, mem_if.addr},
              {126'd0, 2'b11, 32'h0000_3008});
        cyc(); idle_inputs();
        cyc(); rsp_drive(1'b1, 32'h8888_8888);
        cyc(); rsp_clear();
        repeat (3) cyc();
        settle();
        check("sb_drain", {128'd0, 32'(exp_q.size())}, 160'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
